// File: rtl/quadra_coef_lut_pipe.sv
// Runtime-writable multi-bank coefficient table (a, b, c) for the quadratic interpolator,
// read through a two-stage valid/ready pipeline with a pass-through sideband tag.
module quadra_coef_lut_pipe #(
  parameter int ADDR_W    = 7,
  parameter int A_W       = 25,
  parameter int B_W       = 19,
  parameter int C_W       = 15,
  parameter int NUM_BANKS = 2,
  parameter int TAG_W     = 8,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BANK_W-1:0] in_bank,
  input  logic [ADDR_W-1:0] in_x1,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_W-1:0]    out_a,
  output logic [B_W-1:0]    out_b,
  output logic [C_W-1:0]    out_c,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [A_W-1:0]    wr_a,
  input  logic [B_W-1:0]    wr_b,
  input  logic [C_W-1:0]    wr_c
);

  localparam int D_W   = A_W + B_W + C_W;
  localparam int IDX_W = BANK_W + ADDR_W;
  localparam logic [BANK_W:0] BANKS = NUM_BANKS[BANK_W:0];

  // Storage is never reset: coefficients must survive a pipeline reset.
  logic [D_W-1:0]    r_mem [0:(2**IDX_W)-1];

  logic              r_s1_valid;
  logic [BANK_W-1:0] r_s1_bank;
  logic [ADDR_W-1:0] r_s1_x1;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_out_valid;
  logic [A_W-1:0]    r_out_a;
  logic [B_W-1:0]    r_out_b;
  logic [C_W-1:0]    r_out_c;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_adv2;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [D_W-1:0]    w_rd_data;

  assign w_adv2   = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~rst_n | ~r_s1_valid | w_adv2;
  assign w_rd_ok  = ({1'b0, r_s1_bank} < BANKS);
  assign w_wr_ok  = ({1'b0, wr_bank} < BANKS);

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_c     = r_out_c;
  assign out_tag   = r_out_tag;

  // Table read for the request held in s1; out-of-range banks read as zero.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_ok) begin
      w_rd_data = r_mem[{r_s1_bank, r_s1_x1}];
    end else begin
      w_rd_data = '0;
    end
  end

  // Table write port; a same-edge read still sees the previous contents.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && w_wr_ok) begin
      r_mem[{wr_bank, wr_addr}] <= {wr_a, wr_b, wr_c};
    end
  end

  // Stage s1: capture bank/index/tag whenever the stage can take a new request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      r_s1_bank  <= in_bank;
      r_s1_x1    <= in_x1;
      r_s1_tag   <= in_tag;
    end
  end

  // Stage s2: output registers load on advance and hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_c     <= '0;
      r_out_tag   <= '0;
    end else if (w_adv2) begin
      r_out_valid <= 1'b1;
      r_out_a     <= w_rd_data[D_W-1 -: A_W];
      r_out_b     <= w_rd_data[C_W +: B_W];
      r_out_c     <= w_rd_data[C_W-1:0];
      r_out_tag   <= r_s1_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
